// File: rtl/mac_feeder_pkg.sv
// Shared types for the MAC operand feeder: word type and FSM states.
package mac_feeder_pkg;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        SKEW,
        PRESENT,
        HOLD,
        FINISH
    } feeder_state_t;
endpackage

// File: rtl/mac_operand_feeder_buffer.sv
// Operand vector storage: one synchronous write port, one async read port.
module feeder_buffer
    import mac_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output word_t         rdata_o
);
    word_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers one operand vector and streams it into a MAC input port.
// Optional start skew enabled with `define MAC_OPERAND_FEEDER_SKEW_EN.
module mac_operand_feeder
    import mac_feeder_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int FINISH_CYCLES = 2,
    parameter int SKEW_CYCLES   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  word_t                      load_data,
    output logic                       load_ready,
    output logic [$clog2(DEPTH+1)-1:0] load_count,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output word_t                      data_out,
    output logic                       data_waiting,
    output logic                       data_finished,
    input  logic                       data_ready
);
    localparam int LC_W    = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_MAX = (FINISH_CYCLES > SKEW_CYCLES) ? FINISH_CYCLES : SKEW_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    feeder_state_t    state_q, state_d;
    logic [LC_W-1:0]  load_count_q, load_count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_acc;
    logic             last_word;
    word_t            rdata;

    feeder_buffer #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (load_acc),
        .waddr_i (PTR_W'(load_count_q)),
        .wdata_i (load_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign load_ready = (state_q == IDLE) && (load_count_q < LC_W'(DEPTH));
    assign load_acc   = load_valid && load_ready;
    assign last_word  = (LC_W'(rd_ptr_q) + LC_W'(1)) == load_count_q;

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        if (load_acc) begin
            load_count_d = load_count_q + LC_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                // A word loaded in the start cycle counts toward the vector
                if (start && (load_count_q != '0 || load_acc)) begin
`ifdef MAC_OPERAND_FEEDER_SKEW_EN
                    if (SKEW_CYCLES > 0) begin
                        state_d = SKEW;
                        cnt_d   = CNT_W'(SKEW_CYCLES - 1);
                    end else begin
                        state_d = PRESENT;
                    end
`else
                    state_d = PRESENT;
`endif
                end else if (start) begin
                    state_d = FINISH;
                    cnt_d   = CNT_W'(FINISH_CYCLES - 1);
                end
            end
`ifdef MAC_OPERAND_FEEDER_SKEW_EN
            SKEW: begin
                if (cnt_q == '0) begin
                    state_d = PRESENT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            PRESENT: begin
                if (data_ready) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (last_word) begin
                    state_d = FINISH;
                    cnt_d   = CNT_W'(FINISH_CYCLES - 1);
                end else begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    state_d  = PRESENT;
                end
            end
            FINISH: begin
                if (cnt_q == '0) begin
                    state_d      = IDLE;
                    load_count_d = '0;
                    rd_ptr_d     = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            load_count_q <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    // HOLD keeps the operand on the bus while the MAC accumulates it
    assign data_out      = (state_q == PRESENT || state_q == HOLD) ? rdata : '0;
    assign data_waiting  = (state_q == PRESENT);
    assign data_finished = (state_q == FINISH);
    assign done          = (state_q == FINISH) && (cnt_q == '0);
    assign busy          = (state_q != IDLE);
    assign load_count    = load_count_q;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder against a cycle-plan model.
module tb_mac_operand_feeder;
    import mac_feeder_pkg::*;

    localparam int DEPTH = 4;
    localparam int FC    = 2;
    localparam int SK    = 3;
    localparam int LCW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           load_valid = 1'b0;
    word_t          load_data = '0;
    logic           start = 1'b0;
    logic           data_ready = 1'b0;
    logic           load_ready, busy, done, data_waiting, data_finished;
    logic [LCW-1:0] load_count;
    word_t          data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mac_operand_feeder #(
        .DEPTH         (DEPTH),
        .FINISH_CYCLES (FC),
        .SKEW_CYCLES   (SK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .load_count    (load_count),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .data_out      (data_out),
        .data_waiting  (data_waiting),
        .data_finished (data_finished),
        .data_ready    (data_ready)
    );

    typedef struct packed {
        logic  busy;
        logic  waiting;
        logic  finished;
        logic  done;
        logic  lready;
        word_t data;
    } obs_t;

    typedef struct {
        obs_t o;
        logic ready;
    } exp_t;

    function automatic obs_t observe();
        obs_t o;
        o.busy     = busy;
        o.waiting  = data_waiting;
        o.finished = data_finished;
        o.done     = done;
        o.lready   = load_ready;
        o.data     = data_out;
        return o;
    endfunction

    function automatic exp_t mk(logic b, logic w, logic f, logic d,
                                word_t x, logic r);
        exp_t e;
        e.o.busy     = b;
        e.o.waiting  = w;
        e.o.finished = f;
        e.o.done     = d;
        e.o.lready   = 1'b0;
        e.o.data     = x;
        e.ready      = r;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected cycle-by-cycle behaviour of one streamed vector
    task automatic build_plan(input word_t w[$], input int stall[$],
                              output exp_t plan[$]);
        plan.delete();
`ifdef MAC_OPERAND_FEEDER_SKEW_EN
        for (int s = 0; s < SK; s++)
            plan.push_back(mk(1, 0, 0, 0, '0, 1'($urandom)));
`endif
        foreach (w[i]) begin
            for (int k = 0; k <= stall[i]; k++)
                plan.push_back(mk(1, 1, 0, 0, w[i], k == stall[i]));
            plan.push_back(mk(1, 0, 0, 0, w[i], 1'($urandom)));
        end
        for (int f = 0; f < FC; f++)
            plan.push_back(mk(1, 0, 1, f == FC - 1, '0, 1'($urandom)));
    endtask

    task automatic load_words(input word_t w[$]);
        foreach (w[i]) begin
            load_valid = 1'b1;
            load_data  = w[i];
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic kick(input logic with_load, input word_t x);
        start      = 1'b1;
        load_valid = with_load;
        load_data  = x;
        step();
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic run_plan(input string name, input word_t w[$],
                            input int stall[$]);
        exp_t plan[$];
        obs_t o;
        build_plan(w, stall, plan);
        foreach (plan[i]) begin
            data_ready = plan[i].ready;
            start      = 1'($urandom);
            load_valid = 1'($urandom);
            load_data  = $urandom;
            o = observe();
            checks++;
            if (o !== plan[i].o) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h",
                         name, i, o, plan[i].o);
            end
            step();
        end
        start = 1'b0;
        load_valid = 1'b0;
        data_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || load_count !== '0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: busy=%b count=%0d lready=%b expected 0 0 1",
                     name, busy, load_count, load_ready);
        end
    endtask

    task automatic check_count(input string name, input int exp_n);
        checks++;
        if (load_count !== LCW'(exp_n)) begin
            errors++;
            $display("FAIL %s: load_count=%0d expected %0d", name, load_count, exp_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (observe() !== obs_t'({5'b00001, 32'h0}) || load_count !== '0) begin
            errors++;
            $display("FAIL reset: got %h count=%0d expected %h count=0",
                     observe(), load_count, obs_t'({5'b00001, 32'h0}));
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        word_t w[$] = '{32'd2, 32'd3, 32'd4};
        int    s[$] = '{0, 0, 0};
        load_words(w);
        check_count("basic_count", 3);
        kick(1'b0, '0);
        run_plan("basic", w, s);
    endtask

    task automatic test_backpressure();
        word_t w[$] = '{32'd5};
        int    s[$] = '{4};
        load_words(w);
        kick(1'b0, '0);
        run_plan("backpressure", w, s);
    endtask

    task automatic test_empty();
        word_t w[$];
        int    s[$];
        kick(1'b0, '0);
        run_plan("empty", w, s);
    endtask

    task automatic test_full();
        word_t w[$] = '{32'd1, 32'd2, 32'd3, 32'd4};
        int    s[$] = '{1, 0, 2, 0};
        load_words(w);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: load_ready=%b expected 0", load_ready);
        end
        check_count("full_count", 4);
        load_valid = 1'b1;
        load_data  = 32'd9;
        step();
        load_valid = 1'b0;
        check_count("full_overflow", 4);
        kick(1'b0, '0);
        run_plan("full", w, s);
    endtask

    task automatic test_load_and_start();
        word_t w[$] = '{32'hA5A5_0001, 32'hA5A5_0002};
        int    s[$] = '{0, 1, 0};
        load_words(w);
        kick(1'b1, 32'hA5A5_0003);
        w.push_back(32'hA5A5_0003);
        run_plan("load_start", w, s);
    endtask

    task automatic test_reset_midstream();
        word_t w[$] = '{32'd10, 32'd11};
        word_t e[$];
        int    s[$];
        load_words(w);
        kick(1'b0, '0);
`ifdef MAC_OPERAND_FEEDER_SKEW_EN
        for (int i = 0; i < SK; i++) step();
`endif
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        checks++;
        if (data_waiting !== 1'b0 || data_out !== 32'd10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold: waiting=%b data=%h busy=%b expected 0 0000000a 1",
                     data_waiting, data_out, busy);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (observe() !== obs_t'({5'b00001, 32'h0}) || load_count !== '0) begin
            errors++;
            $display("FAIL mid_reset: got %h count=%0d expected %h count=0",
                     observe(), load_count, obs_t'({5'b00001, 32'h0}));
        end
        kick(1'b0, '0);
        run_plan("mid_empty", e, s);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            word_t w[$];
            int    s[$];
            int    n;
            n = $urandom_range(0, DEPTH);
            for (int i = 0; i < n; i++) begin
                w.push_back($urandom);
                s.push_back($urandom_range(0, 3));
            end
            load_words(w);
            check_count("rand_count", n);
            kick(1'b0, '0);
            run_plan("random", w, s);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_full();
        test_load_and_start();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Producer side of the MAC operand handshake: buffers one operand vector (row of A or column of B) and streams it word by word into one MAC input port.
- Drives the MAC's A_in/A_in_waiting/A_in_finished (or B equivalents) and consumes A_in_ready (or B_in_ready).
- Sits between the array's load/controller logic and the edge of the systolic array.
- Instantiate one per MAC input lane.

Parameters:
- DEPTH, 8, maximum vector length in 32-bit words.
- FINISH_CYCLES, 2, number of cycles data_finished is held high at the end of a vector (min 1).
- SKEW_CYCLES, 0, start delay for systolic alignment (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising clk edge).
- load_valid  in  1  load word offered.
- load_data  in  32  word to buffer.
- load_ready  out  1  feeder accepts a load word.
- load_count  out  $clog2(DEPTH+1)  words currently buffered.
- start  in  1  begin streaming the buffered vector.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the last FINISH cycle.
- data_out  out  32  operand to MAC.
- data_waiting  out  1  operand valid; drives MAC *_in_waiting.
- data_finished  out  1  vector complete; drives MAC *_in_finished.
- data_ready  in  1  from MAC *_in_ready.

Behaviour:
- Reset (rst==0): state IDLE, load_count=0, read pointer=0. Outputs: busy=0, done=0, data_out=0, data_waiting=0, data_finished=0. load_ready=1 on the first cycle after reset. Reset applies in any state, including mid-stream.
- States: IDLE, SKEW (optional feature only), PRESENT, HOLD, FINISH.
- IDLE / loading:
  - load_ready = (state==IDLE) && (load_count<DEPTH).
  - On load_valid&&load_ready: buffer[load_count]=load_data and load_count++.
  - load_valid is ignored when load_ready=0; no overwrite when full.
- IDLE / start:
  - start&&load_count>0 -> PRESENT (or SKEW).
  - start&&load_count==0 -> FINISH directly, which yields an empty vector (MAC outputs its current accumulation).
  - start is ignored while busy.
  - Load and start in the same IDLE cycle: both are accepted, and the stream includes the newly loaded word.
- PRESENT: data_out=buffer[rd_ptr], data_waiting=1. A transfer occurs when data_ready=1, and the state moves to HOLD. While data_ready=0, stay in PRESENT with data_out stable.
- HOLD (exactly 1 cycle): data_waiting=0, data_out unchanged, because the MAC samples the operand during its ACCUM cycle.
  - On exit, if rd_ptr==load_count-1 -> FINISH.
  - Otherwise rd_ptr++ -> PRESENT.
- FINISH: data_finished=1, data_waiting=0, data_out=0, held for FINISH_CYCLES cycles using a down-counter.
  - done=1 in the last FINISH cycle.
  - Then go to IDLE and clear load_count and rd_ptr to 0 (the buffer is consumed).
- Latency: with data_ready held high, start at cycle t gives data_waiting at t+1, t+3, …, t+2N-1, and data_finished from t+2N+1.
- Widths: data passes through unmodified. rd_ptr uses $clog2(DEPTH) bits and never wraps, because it is bounded by load_count.

Optional Feature:
- Macro: MAC_OPERAND_FEEDER_SKEW_EN.
- Defined: start enters SKEW and waits SKEW_CYCLES cycles before PRESENT. In SKEW, busy=1 and data_waiting=0. With SKEW_CYCLES=0, SKEW is bypassed.
- Undefined: SKEW does not exist, SKEW_CYCLES is ignored, and start goes straight to PRESENT.

Decomposition:
- Package mac_feeder_pkg contains:
  - WORD_W=32.
  - Typedef feeder_state_t {IDLE, SKEW, PRESENT, HOLD, FINISH}.
  - Typedef word_t logic [WORD_W-1:0].
- Sub-module feeder_buffer: DEPTH x word_t register file with one synchronous write port and one asynchronous read port. No reset of the contents.

Test Plan:
- Load 2,3,4; start at t; data_ready=1 -> data_out 2 @t+1, 3 @t+3, 4 @t+5 with data_waiting high only on those cycles; data_finished t+7..t+8; done @t+8; load_count=0 @t+9.
- Backpressure: load 5; start; data_ready=0 for 4 cycles, then 1 -> data_waiting and data_out=5 stable for 5 cycles, then HOLD, then FINISH.
- Empty start: load_count=0; start @t -> data_finished @t+1..t+2; data_waiting never high; done @t+2.
- Full: DEPTH=4; load 1,2,3,4 -> load_ready=0 and load_count=4; a 5th load_valid with data 9 is ignored; streamed data is 1,2,3,4.
- Reset mid-stream: rst=0 during HOLD after the first word -> next cycle all outputs 0, load_count=0, busy=0; a later start goes down the empty path.
- Skew: with MAC_OPERAND_FEEDER_SKEW_EN, SKEW_CYCLES=3, load 7; start @t -> busy @t+1..t+3 with data_waiting=0; data_waiting with data_out=7 @t+4.
